// File: rtl/fetch_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : fetch_pkg
// Purpose : Shared types, default constants and helpers for the fetch stage.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_TRAP = 2'd1,
        RD_MRET = 2'd2,
        RD_BR   = 2'd3
    } rd_cause_t;

    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : next_pc_sel
// Purpose : Combinational next-PC priority mux (trap > mret > branch > stall).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_stall,
    input  logic        i_trap_take,
    input  logic [31:0] i_trap_vec,
    input  logic        i_mret,
    input  logic [31:0] i_mepc,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    output logic [31:0] o_next_pc,
    output logic        o_flush,
    output rd_cause_t   o_cause
);

    logic [31:0] w_target;

    always_comb begin
        o_cause  = RD_NONE;
        w_target = i_pc;
        if (i_trap_take) begin
            o_cause  = RD_TRAP;
            w_target = i_trap_vec;
        end else if (i_mret) begin
            o_cause  = RD_MRET;
            w_target = i_mepc;
        end else if (i_br_taken) begin
            o_cause  = RD_BR;
            w_target = i_br_target;
        end
        o_flush = (o_cause != RD_NONE);
        // A redirect always beats stall; otherwise stall freezes the PC.
        if (o_flush)
            o_next_pc = align_word(w_target);
        else if (i_stall)
            o_next_pc = i_pc;
        else
            o_next_pc = i_pc + 32'd4;
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : fetch_unit
// Purpose : Instruction fetch stage: PC, IF/ID register, BOOT/RUN/HALT FSM.
//           Optional misaligned-redirect check under FETCH_MISALIGN_CHK_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = C_RESET_PC,
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        trap_take_i,
    input  logic [31:0] trap_vec_i,
    input  logic        mret_i,
    input  logic [31:0] mepc_i,
    input  logic        halt_req_i,
    input  logic        irq_pending_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic        id_valid_o,
    output logic [1:0]  fetch_state_o
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign_o,
    output logic [31:0] fetch_bad_addr_o
`endif
);

    logic [31:0]  r_pc;
    fetch_state_t r_state;
    logic [31:0]  w_next_pc;
    logic         w_flush;
    rd_cause_t    w_cause;
    logic         w_misalign;
    logic         w_locked;

    assign imem_addr     = r_pc;
    assign fetch_state_o = r_state;

    next_pc_sel u_next_pc_sel (
        .i_pc        (r_pc),
        .i_stall     (stall_i),
        .i_trap_take (trap_take_i),
        .i_trap_vec  (trap_vec_i),
        .i_mret      (mret_i),
        .i_mepc      (mepc_i),
        .i_br_taken  (br_taken_i),
        .i_br_target (br_target_i),
        .o_next_pc   (w_next_pc),
        .o_flush     (w_flush),
        .o_cause     (w_cause)
    );

`ifdef FETCH_MISALIGN_CHK_EN
    logic [31:0] w_raw_target;
    logic        r_mis_lock;

    always_comb begin
        case (w_cause)
            RD_TRAP: w_raw_target = trap_vec_i;
            RD_MRET: w_raw_target = mepc_i;
            default: w_raw_target = br_target_i;
        endcase
    end

    assign w_misalign = w_flush && (w_raw_target[1:0] != 2'b00);
    assign w_locked   = r_mis_lock;

    // After a misaligned redirect the stage keeps flushing until a trap lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_misalign_o <= 1'b0;
            fetch_bad_addr_o <= 32'd0;
            r_mis_lock       <= 1'b0;
        end else begin
            fetch_misalign_o <= 1'b0;
            if (r_state == RUN) begin
                if (w_misalign) begin
                    fetch_misalign_o <= 1'b1;
                    fetch_bad_addr_o <= w_raw_target;
                    r_mis_lock       <= 1'b1;
                end else if (trap_take_i) begin
                    r_mis_lock       <= 1'b0;
                end
            end
        end
    end
`else
    assign w_misalign = 1'b0;
    assign w_locked   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_state    <= BOOT;
            id_instr_o <= NOP_INSTR;
            id_pc_o    <= 32'd0;
            id_valid_o <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    id_instr_o <= NOP_INSTR;
                    id_valid_o <= 1'b0;
                    r_state    <= RUN;
                end
                RUN: begin
                    if (w_misalign) begin
                        id_instr_o <= NOP_INSTR;
                        id_valid_o <= 1'b0;
                    end else if (w_flush) begin
                        r_pc       <= w_next_pc;
                        id_instr_o <= NOP_INSTR;
                        id_valid_o <= 1'b0;
                    end else if (w_locked) begin
                        id_instr_o <= NOP_INSTR;
                        id_valid_o <= 1'b0;
                    end else if (stall_i) begin
                        r_pc <= r_pc;
                    end else if (halt_req_i) begin
                        r_pc       <= w_next_pc;
                        id_instr_o <= NOP_INSTR;
                        id_valid_o <= 1'b0;
                        r_state    <= HALT;
                    end else begin
                        r_pc       <= w_next_pc;
                        id_instr_o <= imem_rdata;
                        id_pc_o    <= r_pc;
                        id_valid_o <= 1'b1;
                    end
                end
                HALT: begin
                    id_instr_o <= NOP_INSTR;
                    id_valid_o <= 1'b0;
                    if (trap_take_i) begin
                        r_pc    <= align_word(trap_vec_i);
                        r_state <= RUN;
                    end else if (irq_pending_i) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

endmodule

`default_nettype wire
